bcd_timer_nd: RTL and testbench

- Parametrised N-digit BCD timer that generalises the fixed two-digit 00-99 seconds counter.
- Single clock; an internal prescaler produces a one-cycle count tick.
- Counts up or down over a programmable decimal range 0..MAX_COUNT, with preset load and a wrap or stop-at-terminal mode.
- Drives one 7-segment pattern per digit and carry/borrow pulses for cascading into further timer stages.

---
 rtl/timer_pkg.sv | 46 ++++
 rtl/bcd_timer_nd_cell.sv | 34 +++
 rtl/bcd_timer_nd.sv | 102 ++++++++++
 tb/tb_bcd_timer_nd.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants and elaboration-time helpers for the BCD timer family.
// Segment patterns are {g,f,e,d,c,b,a}, 1 = lit.
package timer_pkg;
   localparam int BCD_W = 4;

   localparam logic [6:0] SEG_0   = 7'b0111111;
   localparam logic [6:0] SEG_1   = 7'b0000110;
   localparam logic [6:0] SEG_2   = 7'b1011011;
   localparam logic [6:0] SEG_3   = 7'b1001111;
   localparam logic [6:0] SEG_4   = 7'b1100110;
   localparam logic [6:0] SEG_5   = 7'b1101101;
   localparam logic [6:0] SEG_6   = 7'b1111101;
   localparam logic [6:0] SEG_7   = 7'b0000111;
   localparam logic [6:0] SEG_8   = 7'b1111111;
   localparam logic [6:0] SEG_9   = 7'b1101111;
   localparam logic [6:0] SEG_OFF = 7'b0000000;

   // Binary to packed BCD, up to 8 digits; used to build the terminal constant.
   function automatic logic [31:0] to_bcd(input int unsigned v);
      logic [31:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r[BCD_W*i +: BCD_W] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: seg_of = SEG_0;
         4'd1: seg_of = SEG_1;
         4'd2: seg_of = SEG_2;
         4'd3: seg_of = SEG_3;
         4'd4: seg_of = SEG_4;
         4'd5: seg_of = SEG_5;
         4'd6: seg_of = SEG_6;
         4'd7: seg_of = SEG_7;
         4'd8: seg_of = SEG_8;
         4'd9: seg_of = SEG_9;
         default: seg_of = SEG_OFF;
      endcase
   endfunction
endpackage

// File: rtl/bcd_timer_nd_cell.sv
// One 0..9 BCD digit: load, forced terminal value, or a step gated by the
// ripple chain. cout is high when this digit would roll over.
module bcd_digit_cell
   import timer_pkg::*;
(
   input  logic       clk_50MHz,
   input  logic       clr,
   input  logic       load,
   input  logic [3:0] load_d,
   input  logic       cin,
   input  logic       step_en,
   input  logic       up_dn,
   input  logic       term,
   input  logic [3:0] term_d,
   output logic [3:0] d,
   output logic       cout,
   output logic [6:0] seg
);
   assign cout = cin & (up_dn ? (d == 4'd9) : (d == 4'd0));
   assign seg  = seg_of(d);

   always_ff @(posedge clk_50MHz) begin
      if (!clr)
         d <= 4'd0;
      else if (load)
         d <= load_d;
      else if (term)
         d <= term_d;
      else if (step_en && cin) begin
         if (up_dn) d <= (d == 4'd9) ? 4'd0 : d + 4'd1;
         else       d <= (d == 4'd0) ? 4'd9 : d - 4'd1;
      end
   end
endmodule

// File: rtl/bcd_timer_nd.sv
// N-digit BCD up/down timer with prescaler, clamped preset load,
// wrap/stop terminal handling and cascade carry/borrow pulses.
module bcd_timer_nd
   import timer_pkg::*;
#(
   parameter int CLK_HZ    = 50000000,
   parameter int TICK_HZ   = 1,
   parameter int DIGITS    = 2,
   parameter int MAX_COUNT = 99
) (
   input  logic                  clk_50MHz,
   input  logic                  clr,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  stop_tc,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  cn,
   output logic                  bw,
   output logic                  done,
   output logic                  tick
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int W   = BCD_W * DIGITS;
   localparam logic [31:0]   MAX_BCD32 = to_bcd(MAX_COUNT);
   localparam logic [W-1:0]  MAX_BCD   = MAX_BCD32[W-1:0];
   localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);

   if (DIV < 2) begin : g_div_chk
      $error("bcd_timer_nd: CLK_HZ/TICK_HZ must be >= 2");
   end
   if (DIGITS < 1 || DIGITS > 8) begin : g_dig_chk
      $error("bcd_timer_nd: DIGITS must be 1..8");
   end
   if (MAX_COUNT < 1 || MAX_COUNT > 10**DIGITS - 1) begin : g_max_chk
      $error("bcd_timer_nd: MAX_COUNT out of range");
   end

   logic [PW-1:0]   presc;
   logic [W-1:0]    load_eff;
   logic            nib_bad;
   logic [DIGITS:0] chain;
   logic            term_hit, adv, wrap, step;

   assign tick = en && (presc == PRE_LAST);

   always_ff @(posedge clk_50MHz) begin
      if (!clr)          presc <= '0;
      else if (load)     presc <= '0;
      else if (en)       presc <= tick ? '0 : presc + 1'b1;
   end

   always_comb begin
      nib_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (load_val[BCD_W*i +: BCD_W] > 4'd9) nib_bad = 1'b1;
      load_eff = (nib_bad || load_val > MAX_BCD) ? MAX_BCD : load_val;
   end

   // chain[0] is tied high so chain[DIGITS] doubles as an "all digits at
   // the roll value" probe; in down mode that is exactly bcd == 0.
   assign chain[0] = 1'b1;
   assign term_hit = up_dn ? (bcd == MAX_BCD) : chain[DIGITS];
   assign adv      = tick & ~load;
   assign wrap     = adv & term_hit & ~stop_tc;
   assign step     = adv & ~term_hit;

   for (genvar k = 0; k < DIGITS; k++) begin : g_dig
      bcd_digit_cell u_cell (
         .clk_50MHz (clk_50MHz),
         .clr       (clr),
         .load      (load),
         .load_d    (load_eff[BCD_W*k +: BCD_W]),
         .cin       (chain[k]),
         .step_en   (step),
         .up_dn     (up_dn),
         .term      (wrap),
         .term_d    (up_dn ? 4'd0 : MAX_BCD[BCD_W*k +: BCD_W]),
         .d         (bcd[BCD_W*k +: BCD_W]),
         .cout      (chain[k+1]),
         .seg       (seg[7*k +: 7])
      );
   end

   always_ff @(posedge clk_50MHz) begin
      if (!clr) begin
         cn   <= 1'b0;
         bw   <= 1'b0;
         done <= 1'b0;
      end else begin
         cn <= wrap & up_dn;
         bw <= wrap & ~up_dn;
         if (load)
            done <= stop_tc && (load_eff == (up_dn ? MAX_BCD : W'(0)));
         else if (adv)
            done <= term_hit & stop_tc;
      end
   end
endmodule

// File: tb/tb_bcd_timer_nd.sv
// Scoreboard bench for bcd_timer_nd (2 digits, 0..59, DIV=4): a behavioural
// integer model pushes expected outputs per cycle, each test pops and compares.
module tb_bcd_timer_nd;
   logic        clk_50MHz = 1'b0;
   logic        clr = 1'b0, en = 1'b0, up_dn = 1'b1, stop_tc = 1'b0, load = 1'b0;
   logic [7:0]  load_val = '0;
   logic [7:0]  bcd;
   logic [13:0] seg;
   logic        cn, bw, done, tick;
   logic [25:0] obs, exp_v;

   always #5 clk_50MHz = ~clk_50MHz;

   bcd_timer_nd #(.CLK_HZ(4), .TICK_HZ(1), .DIGITS(2), .MAX_COUNT(59)) dut (
      .clk_50MHz (clk_50MHz),
      .clr       (clr),
      .en        (en),
      .up_dn     (up_dn),
      .stop_tc   (stop_tc),
      .load      (load),
      .load_val  (load_val),
      .bcd       (bcd),
      .seg       (seg),
      .cn        (cn),
      .bw        (bw),
      .done      (done),
      .tick      (tick)
   );

   assign obs = {bcd, seg, cn, bw, done, tick};

   logic [6:0]  segt [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   logic [25:0] sb [$];
   int n_cmp = 0, n_err = 0;
   int m_pre = 0, m_cnt = 0;
   bit m_cn = 0, m_bw = 0, m_done = 0;

   // Drive one cycle of inputs, advance the model, queue the expected outputs.
   task automatic drive(input bit c, input bit e, input bit u, input bit s,
                        input bit l, input logic [7:0] lv);
      bit mt;
      int v;
      @(negedge clk_50MHz);
      clr = c; en = e; up_dn = u; stop_tc = s; load = l; load_val = lv;
      mt = e && (m_pre == 3);
      m_cn = 0; m_bw = 0;
      if (!c) begin
         m_pre = 0; m_cnt = 0; m_done = 0;
      end else if (l) begin
         v = int'(lv[7:4]) * 10 + int'(lv[3:0]);
         if (lv[7:4] > 4'd9 || lv[3:0] > 4'd9 || v > 59) v = 59;
         m_cnt = v; m_pre = 0; m_done = s && (v == (u ? 59 : 0));
      end else begin
         if (e) m_pre = (m_pre == 3) ? 0 : m_pre + 1;
         if (mt) begin
            if (u) begin
               if (m_cnt < 59)  begin m_cnt++; m_done = 0; end
               else if (s)      m_done = 1;
               else             begin m_cnt = 0; m_cn = 1; m_done = 0; end
            end else begin
               if (m_cnt > 0)   begin m_cnt--; m_done = 0; end
               else if (s)      m_done = 1;
               else             begin m_cnt = 59; m_bw = 1; m_done = 0; end
            end
         end
      end
      sb.push_back({8'((m_cnt / 10) * 16 + m_cnt % 10), segt[m_cnt / 10],
                    segt[m_cnt % 10], m_cn, m_bw, m_done, e && (m_pre == 3)});
      @(posedge clk_50MHz);
      #1;
   endtask

   task automatic test_reset();
      drive(0, 0, 1, 0, 0, 8'h00);
      drive(0, 1, 1, 1, 1, 8'h42);
      for (int i = 0; i < 2; i++) begin
         exp_v = sb.pop_front(); n_cmp++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL reset[%0d]: got %h want %h", i, obs, exp_v);
         end
      end
      n_cmp++;
      if (obs !== {8'h00, 7'b0111111, 7'b0111111, 4'b0000}) begin
         n_err++; $display("FAIL reset_const: got %h want %h", obs, {8'h00, 14'h1FBF, 4'b0});
      end
   endtask

   task automatic test_count_up_wrap();
      int ncn = 0;
      for (int i = 0; i < 240; i++) begin
         drive(1, 1, 1, 0, 0, 8'h00);
         exp_v = sb.pop_front(); n_cmp++;
         if (cn) ncn++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL up_wrap cyc %0d: got %h want %h", i, obs, exp_v);
         end
      end
      n_cmp++;
      if (ncn !== 1 || bcd !== 8'h00 || seg[6:0] !== 7'b0111111) begin
         n_err++; $display("FAIL up_wrap_end: cn pulses %0d bcd %h seg %h want 1 00 3f",
                           ncn, bcd, seg[6:0]);
      end
   endtask

   task automatic test_down_wrap();
      int nbw = 0;
      for (int i = 0; i < 12; i++) begin
         drive(1, 1, 0, 0, 0, 8'h00);
         exp_v = sb.pop_front(); n_cmp++;
         if (bw) nbw++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL down_wrap cyc %0d: got %h want %h", i, obs, exp_v);
         end
      end
      n_cmp++;
      if (nbw !== 1 || bcd !== 8'h57) begin
         n_err++; $display("FAIL down_wrap_end: bw pulses %0d bcd %h want 1 57", nbw, bcd);
      end
   endtask

   task automatic test_stop_tc();
      drive(1, 1, 1, 1, 1, 8'h57);
      for (int i = 0; i < 16; i++) drive(1, 1, 1, 1, 0, 8'h00);
      for (int i = 0; i < 4; i++)  drive(1, 1, 0, 1, 0, 8'h00);
      for (int i = 0; i < 21; i++) begin
         exp_v = sb.pop_front(); n_cmp++;
         if (obs !== exp_v && i == 20) begin
            n_err++; $display("FAIL stop_tc final: got %h want %h", obs, exp_v);
         end
      end
      n_cmp++;
      if (bcd !== 8'h58 || done !== 1'b0) begin
         n_err++; $display("FAIL stop_tc_release: bcd %h done %b want 58 0", bcd, done);
      end
   endtask

   task automatic test_stop_hold();
      int ncn = 0;
      drive(1, 1, 1, 1, 1, 8'h57);
      exp_v = sb.pop_front();
      for (int i = 0; i < 16; i++) begin
         drive(1, 1, 1, 1, 0, 8'h00);
         exp_v = sb.pop_front(); n_cmp++;
         if (cn) ncn++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL stop_hold cyc %0d: got %h want %h", i, obs, exp_v);
         end
      end
      n_cmp++;
      if (ncn !== 0 || bcd !== 8'h59 || done !== 1'b1) begin
         n_err++; $display("FAIL stop_hold_end: cn %0d bcd %h done %b want 0 59 1", ncn, bcd, done);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 0, 1, 0, 8'h00);
         exp_v = sb.pop_front(); n_cmp++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL stop_flip cyc %0d: got %h want %h", i, obs, exp_v);
         end
      end
   endtask

   task automatic test_load_clamp();
      for (int i = 0; i < 4 && m_pre != 3; i++) begin
         drive(1, 1, 1, 0, 0, 8'h00);
         exp_v = sb.pop_front();
      end
      drive(1, 1, 1, 0, 1, 8'h7A);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v || bcd !== 8'h59) begin
         n_err++; $display("FAIL load_clamp: got %h want %h", obs, exp_v);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 1, 0, 0, 8'h00);
         exp_v = sb.pop_front(); n_cmp++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL load_restart cyc %0d: got %h want %h", i, obs, exp_v);
         end
      end
      drive(1, 1, 1, 0, 1, 8'h45);
      drive(1, 1, 1, 0, 1, 8'h60);
      drive(1, 1, 0, 1, 1, 8'h00);
      for (int i = 0; i < 3; i++) begin
         exp_v = sb.pop_front(); n_cmp++;
         if (i == 2 && obs !== exp_v) begin
            n_err++; $display("FAIL load_zero_done: got %h want %h", obs, exp_v);
         end
      end
   endtask

   task automatic test_en_gap();
      int ntk = 0;
      for (int i = 0; i < 4 && m_pre != 2; i++) begin
         drive(1, 1, 1, 0, 0, 8'h00);
         exp_v = sb.pop_front();
      end
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 1, 0, 0, 8'h00);
         exp_v = sb.pop_front(); n_cmp++;
         if (tick) ntk++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL en_gap cyc %0d: got %h want %h", i, obs, exp_v);
         end
      end
      drive(1, 1, 1, 0, 0, 8'h00);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v || tick !== 1'b1 || ntk !== 0) begin
         n_err++; $display("FAIL en_resume: got %h want %h gap ticks %0d", obs, exp_v, ntk);
      end
   endtask

   task automatic test_mid_reset();
      drive(1, 1, 1, 0, 1, 8'h37);
      drive(1, 1, 1, 0, 0, 8'h00);
      drive(1, 1, 1, 0, 0, 8'h00);
      for (int i = 0; i < 3; i++) exp_v = sb.pop_front();
      n_cmp++;
      if (bcd !== 8'h37) begin
         n_err++; $display("FAIL mid_reset_pre: bcd %h want 37", bcd);
      end
      drive(0, 1, 1, 0, 0, 8'h00);
      exp_v = sb.pop_front(); n_cmp++;
      if (obs !== exp_v || obs !== {8'h00, 7'b0111111, 7'b0111111, 4'b0000}) begin
         n_err++; $display("FAIL mid_reset: got %h want %h", obs, exp_v);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 1, 0, 0, 8'h00);
         exp_v = sb.pop_front(); n_cmp++;
         if (obs !== exp_v) begin
            n_err++; $display("FAIL mid_reset_restart cyc %0d: got %h want %h", i, obs, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_up_wrap();
      test_down_wrap();
      test_stop_hold();
      test_stop_tc();
      test_load_clamp();
      test_en_gap();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
